// File: rtl/uart_csr_arbiter_if.sv
// Request/response channel between the CSR bus masters and the UART CSR arbiter.
// Per-requester fields are packed; requester i owns slice i of each vector.
interface uart_csr_arbiter_if #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/uart_csr_arbiter.sv
// Round-robin arbiter sharing the UART CSR port among N_REQ masters; one access per
// 3-cycle transaction so read-to-clear side effects fire exactly once.
module uart_csr_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_csr_arbiter_if.slave        bus,
    output logic                     csr_wen,
    output logic [ADDR_WIDTH-1:0]    csr_wr_addr,
    output logic [DATA_WIDTH-1:0]    csr_wr_data,
    output logic                     csr_ren,
    output logic [ADDR_WIDTH-1:0]    csr_rd_addr,
    input  logic [DATA_WIDTH-1:0]    csr_rd_data,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

    state_e                state_q;
    logic [IdxW-1:0]       ptr_q;
    logic [IdxW-1:0]       owner_q;
    logic                  cmd_we_q;
    logic                  csr_wen_q;
    logic                  csr_ren_q;
    logic [ADDR_WIDTH-1:0] csr_wr_addr_q;
    logic [DATA_WIDTH-1:0] csr_wr_data_q;
    logic [ADDR_WIDTH-1:0] csr_rd_addr_q;

    logic                  grant_found;
    logic [IdxW-1:0]       grant_idx;
    logic [IdxW-1:0]       scan_idx;
    int unsigned           scan;

    // First valid requester scanning ptr, ptr+1, ... with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan = 32'(ptr_q) + i;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            scan_idx = IdxW'(scan);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle && grant_found && !rst) ?
                           (N_REQ'(1) << grant_idx) : '0;
    // Gating with rst keeps an aborted transaction from ever completing.
    assign bus.rsp_valid = (state_q == StResp && !rst) ? (N_REQ'(1) << owner_q) : '0;
    assign bus.rsp_rdata = (state_q == StResp && !rst && !cmd_we_q) ? csr_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            owner_q       <= '0;
            cmd_we_q      <= 1'b0;
            csr_wen_q     <= 1'b0;
            csr_ren_q     <= 1'b0;
            csr_wr_addr_q <= '0;
            csr_wr_data_q <= '0;
            csr_rd_addr_q <= '0;
        end else begin
            csr_wen_q <= 1'b0;
            csr_ren_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        owner_q  <= grant_idx;
                        cmd_we_q <= bus.req_we[grant_idx];
                        if (bus.req_we[grant_idx]) begin
                            csr_wen_q     <= 1'b1;
                            csr_wr_addr_q <= bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                            csr_wr_data_q <= bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            csr_ren_q     <= 1'b1;
                            csr_rd_addr_q <= bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                        state_q <= StCmd;
                    end
                end
                StCmd: state_q <= StResp;
                StResp: begin
                    ptr_q   <= (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign csr_wen     = csr_wen_q;
    assign csr_ren     = csr_ren_q;
    assign csr_wr_addr = csr_wr_addr_q;
    assign csr_wr_data = csr_wr_data_q;
    assign csr_rd_addr = csr_rd_addr_q;
    assign busy        = (state_q != StIdle);
    assign owner       = owner_q;
endmodule

// File: tb/tb_uart_csr_arbiter.sv
// Randomised scoreboard bench for uart_csr_arbiter with three requesters, a CSR file
// model that clears one address on read, and occasional resets mid-transaction.
module tb_uart_csr_arbiter;
    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int RtcAddr = 2;
    localparam int RunCycles = 3000;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        int          due;
    } rsp_exp_t;

    typedef struct {
        bit          we;
        logic [2:0]  addr;
        logic [31:0] data;
        int          due;
    } csr_exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           csr_wen;
    logic [AW-1:0]  csr_wr_addr;
    logic [DW-1:0]  csr_wr_data;
    logic           csr_ren;
    logic [AW-1:0]  csr_rd_addr;
    logic [DW-1:0]  csr_rd_data;
    logic           busy;
    logic [1:0]     owner;

    uart_csr_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    uart_csr_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .csr_wen     (csr_wen),
        .csr_wr_addr (csr_wr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_ren     (csr_ren),
        .csr_rd_addr (csr_rd_addr),
        .csr_rd_data (csr_rd_data),
        .busy        (busy),
        .owner       (owner)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR register file; RtcAddr clears when read.
    logic [31:0] csr_mem [8];
    always @(posedge clk) begin
        if (csr_wen) csr_mem[csr_wr_addr] <= csr_wr_data;
        if (csr_ren) begin
            csr_rd_data <= csr_mem[csr_rd_addr];
            if (int'(csr_rd_addr) == RtcAddr) csr_mem[csr_rd_addr] <= '0;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    rsp_exp_t rsp_q [$];
    csr_exp_t csr_q [$];
    bit       mon_en = 1'b0;

    // Driver state and reference model state.
    bit          drv_valid [N];
    bit          drv_we    [N];
    logic [2:0]  drv_addr  [N];
    logic [31:0] drv_data  [N];
    bit          waiting   [N];
    logic [31:0] ref_mem   [8];
    int          bcnt, mptr, mowner;

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]            = drv_valid[i];
            bus.req_we[i]               = drv_we[i];
            bus.req_addr[i*AW +: AW]    = drv_addr[i];
            bus.req_wdata[i*DW +: DW]   = drv_data[i];
        end
    endtask

    task automatic new_request(input int i);
        drv_valid[i] = 1'b1;
        drv_we[i]    = 1'($urandom_range(0, 1));
        drv_addr[i]  = 3'($urandom_range(0, 7));
        drv_data[i]  = $urandom;
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or CSR pulse.
    initial begin
        rsp_exp_t e;
        csr_exp_t c;
        logic [N-1:0] oh;
        bit prev_wen = 1'b0;
        bit prev_ren = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst) begin
                    rsp_q.delete();
                    while (csr_q.size() > 0 && csr_q[csr_q.size()-1].due > cyc)
                        void'(csr_q.pop_back());
                    check("rsp_during_reset", 64'(bus.rsp_valid), 64'(0));
                end
                while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
                    e = rsp_q.pop_front();
                    check("rsp_missing_id", 64'(-1), 64'(e.id));
                end
                if (bus.rsp_valid != '0) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
                    end else begin
                        e  = rsp_q.pop_front();
                        oh = '0;
                        oh[e.id] = 1'b1;
                        check("rsp_owner", 64'(bus.rsp_valid), 64'(oh));
                        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                        check("rsp_cycle", 64'(cyc), 64'(e.due));
                    end
                end
                check("wen_ren_exclusive", 64'(csr_wen & csr_ren), 64'(0));
                check("no_back_to_back", 64'((csr_wen & prev_wen) | (csr_ren & prev_ren)),
                      64'(0));
                prev_wen = csr_wen;
                prev_ren = csr_ren;
                while (csr_q.size() > 0 && csr_q[0].due < cyc) begin
                    c = csr_q.pop_front();
                    check("csr_pulse_missing", 64'(0), 64'(1));
                end
                if (csr_wen || csr_ren) begin
                    if (csr_q.size() == 0) begin
                        check("csr_unexpected", 64'({csr_wen, csr_ren}), 64'(0));
                    end else begin
                        c = csr_q.pop_front();
                        check("csr_kind", 64'({csr_wen, csr_ren}), 64'({c.we, !c.we}));
                        check("csr_cycle", 64'(cyc), 64'(c.due));
                        if (c.we) begin
                            check("csr_wr_addr", 64'(csr_wr_addr), 64'(c.addr));
                            check("csr_wr_data", 64'(csr_wr_data), 64'(c.data));
                        end else begin
                            check("csr_rd_addr", 64'(csr_rd_addr), 64'(c.addr));
                        end
                    end
                end
            end
        end
    end

    // Stimulus and reference model.
    initial begin
        int prob, n_abort, last_abort, w;
        bit found;
        logic [N-1:0] exp_ready;
        logic [31:0]  r;

        n_abort    = 0;
        last_abort = 0;
        for (int a = 0; a < 8; a++) begin
            csr_mem[a] = $urandom;
            ref_mem[a] = csr_mem[a];
        end
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            new_request(i);
            waiting[i] = 1'b0;
        end
        drive_bus();
        bcnt = 0; mptr = 0; mowner = 0;

        // Reset held two cycles with every requester asking.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("reset_req_ready", 64'(bus.req_ready), 64'(0));
            check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
            check("reset_busy",      64'(busy), 64'(0));
            check("reset_owner",     64'(owner), 64'(0));
            check("reset_csr_en",    64'({csr_wen, csr_ren}), 64'(0));
            check("reset_csr_addr",  64'({csr_wr_addr, csr_rd_addr}), 64'(0));
            check("reset_csr_wdata", 64'(csr_wr_data), 64'(0));
        end

        mon_en = 1'b1;
        for (int t = 0; t < RunCycles; t++) begin
            @(posedge clk);
            #1;
            // Occasionally reset during CMD (bcnt 2) or RESP (bcnt 1).
            rst = (cyc > 500 && n_abort < 6 && cyc - last_abort > 40 &&
                   bcnt == ((n_abort % 2 == 1) ? 1 : 2));
            if (rst) begin
                n_abort++;
                last_abort = cyc;
            end
            prob = (t < 300) ? 100 : (t < 1500) ? 50 : (t < RunCycles - 30) ? 20 : 0;
            for (int i = 0; i < N; i++)
                if (!drv_valid[i] && !waiting[i] && $urandom_range(0, 99) < prob)
                    new_request(i);
            drive_bus();

            @(negedge clk);
            check("busy",  64'(busy), 64'(bcnt != 0));
            check("owner", 64'(owner), 64'(mowner));
            exp_ready = '0;
            if (rst) begin
                bcnt = 0; mptr = 0; mowner = 0;
            end else if (bcnt == 0) begin
                found = 1'b0;
                w     = 0;
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = (mptr + i) % N;
                    if (!found && drv_valid[j]) begin
                        found = 1'b1;
                        w     = j;
                    end
                end
                if (found) begin
                    exp_ready[w] = 1'b1;
                    if (drv_we[w]) begin
                        ref_mem[drv_addr[w]] = drv_data[w];
                        r = '0;
                    end else begin
                        r = ref_mem[drv_addr[w]];
                        if (int'(drv_addr[w]) == RtcAddr) ref_mem[drv_addr[w]] = '0;
                    end
                    rsp_q.push_back('{id: w, rdata: r, due: cyc + 2});
                    csr_q.push_back('{we: drv_we[w], addr: drv_addr[w], data: drv_data[w],
                                      due: cyc + 1});
                    mowner = w;
                    mptr   = (w + 1) % N;
                    bcnt   = 2;
                end
            end else begin
                bcnt--;
            end
            check("req_ready", 64'(bus.req_ready), 64'(exp_ready));

            for (int i = 0; i < N; i++) begin
                if (drv_valid[i] && bus.req_ready[i]) begin
                    drv_valid[i] = 1'b0;
                    waiting[i]   = 1'b1;
                end
                if (bus.rsp_valid[i] || rst) waiting[i] = 1'b0;
            end
        end

        @(negedge clk);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
        check("csr_queue_drained", 64'(csr_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
